// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter, next-PC select and run/step/halt/trap commit controller
// Optional feature macro: PC_FETCH_BP_EN builds the breakpoint comparator; when undefined,
// bp_en_i and bp_addr_i are ignored.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   run_i, step_i, stall_i    free-run level, single-step request (rising edge), stall
//   br_taken_i, jal_i, jalr_i control-flow selects (priority jalr > jal > branch)
//   imm_i, rs1_i              byte offset and JALR base
//   bp_en_i, bp_addr_i        hardware breakpoint
//   pc_o, pc_plus4_o          current PC and link value
//   imem_addr_o               instruction-memory word address
//   commit_o                  current instruction retires
//   state_o, halted_o         IDLE=00 RUN=01 STEP=10 TRAP=11, halted in IDLE/TRAP
//   misalign_o                trapped on a misaligned target
//   retired_cnt_o             committed-instruction counter
module pc_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int IMEM_AW = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              run_i,
  input  logic              step_i,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic              jal_i,
  input  logic              jalr_i,
  input  logic [ADDR_W-1:0] imm_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic              bp_en_i,
  input  logic [ADDR_W-1:0] bp_addr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic              commit_o,
  output logic [1:0]        state_o,
  output logic              halted_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  retired_cnt_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, TRAP = 2'b11} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] tgt;
  logic jump, misaligned, active, fault, bp_hit, step_rise;
  // Holds "step_i was low at the last edge"; resetting it to 0 means a step_i
  // held high through reset release is not seen as a rising edge.
  logic step_low;
  assign jump = jalr_i | jal_i | br_taken_i;
  assign tgt = jalr_i ? ((rs1_i + imm_i) & ~ADDR_W'(1)) :
               (jal_i | br_taken_i) ? pc_o + imm_i : pc_plus4_o;
  assign misaligned = jump & tgt[1];
  assign active = (state == RUN) | (state == STEP);
  assign fault = active & ~stall_i & misaligned;
  assign commit_o = active & ~stall_i & ~misaligned;
  assign step_rise = step_i & step_low;
`ifdef PC_FETCH_BP_EN
  assign bp_hit = commit_o & bp_en_i & (tgt == bp_addr_i);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en_i, bp_addr_i};
  assign bp_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      pc_o <= RESET_PC;
      retired_cnt_o <= '0;
      step_low <= 1'b0;
    end else begin
      state <= state_n;
      step_low <= ~step_i;
      if (commit_o) begin
        pc_o <= tgt;
        retired_cnt_o <= retired_cnt_o + CNT_W'(1);
      end
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = run_i ? RUN : step_rise ? STEP : IDLE;
      RUN:  state_n = fault ? TRAP : (~run_i | bp_hit) ? IDLE : RUN;
      STEP: state_n = fault ? TRAP : commit_o ? IDLE : STEP;
      default: state_n = TRAP;
    endcase
  end
  assign pc_plus4_o = pc_o + ADDR_W'(4);
  assign imem_addr_o = pc_o[IMEM_AW+1:2];
  assign state_o = state;
  assign halted_o = (state == IDLE) | (state == TRAP);
  assign misalign_o = state == TRAP;
endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Parametrised program-counter and execution controller for the single-cycle RISC-V core, replacing the fixed 5-bit instruction-ROM address register. It computes the next PC from sequential, branch, JAL and JALR inputs, and gates architectural commits through a run/step/halt state machine. It adds a hardware breakpoint, misaligned-target trapping and a retired-instruction counter, all of which feed the board debug display.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits
- IMEM_AW, 5, instruction-memory word-address width
- RESET_PC, 0, PC value after reset (word aligned)
- CNT_W, 32, retired-counter width

Ports:
- clk  in  1  core clock (divided CPU clock); all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- run_i  in  1  level; 1 = free-run
- step_i  in  1  single-step request; rising edge acts
- stall_i  in  1  hold PC and suppress commit this cycle
- br_taken_i  in  1  conditional branch taken (Branch && condition)
- jal_i  in  1  JAL decoded
- jalr_i  in  1  JALR decoded
- imm_i  in  ADDR_W  sign-extended immediate, byte offset
- rs1_i  in  ADDR_W  rs1 value for JALR
- bp_en_i  in  1  breakpoint enable
- bp_addr_i  in  ADDR_W  breakpoint PC
- pc_o  out  ADDR_W  current PC
- pc_plus4_o  out  ADDR_W  pc_o + 4, the JAL/JALR link value
- imem_addr_o  out  IMEM_AW  pc_o[IMEM_AW+1:2]
- commit_o  out  1  current instruction retires; gates RF and DM write enables
- state_o  out  2  IDLE=00, RUN=01, STEP=10, TRAP=11
- halted_o  out  1  state is IDLE or TRAP
- misalign_o  out  1  state is TRAP
- retired_cnt_o  out  CNT_W  count of committed instructions

## Operation
- Next-PC priority is jalr_i, then jal_i, then br_taken_i, then sequential:
  - JALR: (rs1_i + imm_i) & ~1.
  - JAL and branch: pc_o + imm_i.
  - Sequential: pc_o + 4.
  - All sums are modulo 2^ADDR_W.
- The target is misaligned when a jump or taken branch is selected and target[1] = 1.
- active = (state RUN or STEP). commit_o = active & !stall_i & !misaligned, combinational.
- On commit: pc_o ← next PC and retired_cnt_o += 1, wrapping at 2^CNT_W.
- With no commit, pc_o holds.
- imem_addr_o truncates the PC and wraps modulo 2^IMEM_AW words.

State transitions:
- IDLE → RUN when run_i = 1.
- IDLE → STEP on a step_i rising edge with run_i = 0. If both occur together, run wins.
- RUN → IDLE at the edge where run_i = 0; that cycle's instruction still commits if eligible.
- RUN → IDLE on a breakpoint hit: commit occurs and next PC == bp_addr_i with bp_en_i = 1. The halt leaves pc_o = bp_addr_i and that instruction unexecuted.
- STEP → IDLE after exactly one commit. STEP holds while stall_i = 1. A breakpoint is not checked in STEP, so stepping off a breakpoint works.
- RUN or STEP → TRAP when active & !stall_i & misaligned. pc_o holds the faulting instruction's address and there is no commit.
- TRAP exits only through rstn. run_i and step_i are ignored in TRAP.
- step_i edges arriving in RUN, STEP or TRAP are discarded.
- The step edge detector register resets to 0, so a step_i held high across reset release does not trigger a step.

## Timing
- Next-PC, misalign and commit_o are combinational from the current-cycle inputs, giving single-cycle core timing.
- pc_o and state update at the next rising clk.
- After step_i rises, the STEP state is entered on the following edge, and the commit occurs in the STEP cycle.
- Reset values (asynchronous, immediate on rstn low, including mid-run):
  - pc_o = RESET_PC
  - pc_plus4_o = RESET_PC+4
  - imem_addr_o = RESET_PC[IMEM_AW+1:2]
  - state_o = IDLE
  - halted_o = 1
  - commit_o = 0
  - misalign_o = 0
  - retired_cnt_o = 0

## Configuration
- Macro PC_FETCH_BP_EN.
- When defined: the breakpoint comparator is built and behaves as above.
- When undefined: bp_en_i and bp_addr_i remain as ports but are ignored, and RUN never halts on a breakpoint.

## Test plan
- Sequential run: reset, run_i = 1, no jumps, 4 cycles → pc_o steps 0, 4, 8, 12, 16; retired_cnt_o = 4; imem_addr_o = 4.
- Branch and JALR: at pc 8, br_taken_i with imm = −8 → pc_o = 0. JALR with rs1 = 0x21, imm = 3 → pc_o = 0x24 (bit 0 cleared).
- Single step: IDLE at pc 0x10, step_i held high for 5 cycles → exactly one commit, pc_o = 0x14, back in IDLE, retired_cnt_o +1.
- Breakpoint (macro defined): bp_addr = 0xC, run from 0 → IDLE with pc_o = 0xC, retired_cnt_o = 3. A subsequent step → pc_o = 0x10. With the macro undefined, the same stimulus does not halt.
- Misalign trap: at pc 4, jal_i with imm = 6 → commit_o = 0, state TRAP, pc_o = 4, misalign_o = 1. Toggling run_i or step_i has no effect. Asserting rstn low → IDLE with pc_o = 0.
- Stall and reset mid-run: RUN with stall_i high for 3 cycles → pc_o and retired_cnt_o frozen, commit_o = 0. Then rstn pulsed mid-cycle → every output equals its reset value immediately.
